// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 16x oversampling and an internal baud-tick
// divider. Good bytes appear on d_out with a one-cycle rx_done strobe; frames
// whose stop-bit sample is low raise a one-cycle frame_err and leave d_out alone.
//
//   state | meaning
//   IDLE  | line idle, waiting for rx_s low
//   START | counting to mid start bit, rejecting glitches
//   DATA  | sampling DBIT data bits, LSB first, at bit centres
//   STOP  | waiting SB_TICK ticks, then sampling the stop bit
module uart_rx #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16,
   parameter int DIVISOR = 163
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rx,
   output logic [DBIT-1:0] d_out,
   output logic            rx_done,
   output logic            frame_err
);

   localparam int TW = $clog2(DIVISOR);
   localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

   localparam logic [TW-1:0] TICK_MAX = TW'(DIVISOR - 1);
   localparam logic [3:0]    S_MID    = 4'd7;
   localparam logic [3:0]    S_LAST   = 4'd15;
   localparam logic [3:0]    S_STOP   = 4'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST   = NW'(DBIT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t          state, state_n;
   logic            rx_meta, rx_s;
   logic [TW-1:0]   tick_cnt;
   logic            tick;
   logic [3:0]      s_cnt, s_cnt_n;
   logic [NW-1:0]   n_cnt, n_cnt_n;
   logic [DBIT-1:0] sh, sh_n;
   logic [DBIT-1:0] d_out_n;
   logic            rx_done_n, frame_err_n;

   // Two-flop synchronizer; resets to the idle (high) line level.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // Free-running oversample divider, independent of receiver state.
   always_ff @(posedge clk) begin
      if (reset)
         tick_cnt <= '0;
      else if (tick_cnt == TICK_MAX)
         tick_cnt <= '0;
      else
         tick_cnt <= tick_cnt + TW'(1);
   end

   assign tick = (tick_cnt == TICK_MAX);

   // State, counters, shift register and registered strobes.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         s_cnt     <= '0;
         n_cnt     <= '0;
         sh        <= '0;
         d_out     <= '0;
         rx_done   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         s_cnt     <= s_cnt_n;
         n_cnt     <= n_cnt_n;
         sh        <= sh_n;
         d_out     <= d_out_n;
         rx_done   <= rx_done_n;
         frame_err <= frame_err_n;
      end
   end

   // Next-state and datapath decisions; strobes default low every cycle.
   always_comb begin
      state_n     = state;
      s_cnt_n     = s_cnt;
      n_cnt_n     = n_cnt;
      sh_n        = sh;
      d_out_n     = d_out;
      rx_done_n   = 1'b0;
      frame_err_n = 1'b0;

      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_n = START;
               s_cnt_n = '0;
            end
         end
         START: begin
            if (tick) begin
               if (s_cnt == S_MID) begin
                  if (!rx_s) begin
                     state_n = DATA;
                     s_cnt_n = '0;
                     n_cnt_n = '0;
                  end else begin
                     state_n = IDLE;
                  end
               end else begin
                  s_cnt_n = s_cnt + 4'd1;
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (s_cnt == S_LAST) begin
                  // Shift in from the top so the first bit ends up in bit 0.
                  sh_n    = DBIT'({rx_s, sh} >> 1);
                  s_cnt_n = '0;
                  if (n_cnt == N_LAST)
                     state_n = STOP;
                  else
                     n_cnt_n = n_cnt + NW'(1);
               end else begin
                  s_cnt_n = s_cnt + 4'd1;
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (s_cnt == S_STOP) begin
                  state_n = IDLE;
                  if (rx_s) begin
                     d_out_n   = sh;
                     rx_done_n = 1'b1;
                  end else begin
                     frame_err_n = 1'b1;
                  end
               end else begin
                  s_cnt_n = s_cnt + 4'd1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives serial frames into uart_rx and compares the received
// bytes and error strobes with a frame-level reference model.
module tb_uart_rx;

   localparam int DBIT    = 8;
   localparam int SB_TICK = 16;
   localparam int DIVISOR = 2;
   localparam int BIT_CLK = 16 * DIVISOR;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx;
   logic [7:0] d_out;
   logic       rx_done;
   logic       frame_err;

   int tests_run = 0;
   int fails     = 0;

   always #5 clk = ~clk;

   uart_rx #(.DBIT(DBIT), .SB_TICK(SB_TICK), .DIVISOR(DIVISOR)) dut (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .d_out     (d_out),
      .rx_done   (rx_done),
      .frame_err (frame_err)
   );

   // Observed traffic
   logic [7:0] got_q[$];
   int         got_err     = 0;
   int         overlap_cnt = 0;
   int         wide_cnt    = 0;
   logic       prev_done   = 1'b0;
   logic       prev_err    = 1'b0;

   // Reference model: one entry per frame, expected d_out is the last good byte
   logic [7:0] exp_q[$];
   int         exp_err  = 0;
   logic [7:0] exp_dout = 8'h00;

   always @(negedge clk) begin
      if (rx_done) got_q.push_back(d_out);
      if (frame_err) got_err++;
      if (rx_done && frame_err) overlap_cnt++;
      if ((rx_done && prev_done) || (frame_err && prev_err)) wide_cnt++;
      prev_done = rx_done;
      prev_err  = frame_err;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic clear_obs();
      @(posedge clk);
      got_q.delete();
      got_err = 0;
      exp_q.delete();
      exp_err = 0;
      @(negedge clk);
   endtask

   task automatic idle_bits(input int n);
      rx = 1'b1;
      repeat (n * BIT_CLK) @(negedge clk);
   endtask

   // A bad frame holds the stop bit low for its first three quarters only, so
   // the receiver's re-arm on the low line resolves as a glitch before the
   // next frame.
   task automatic send_frame(input logic [7:0] b, input bit good);
      rx = 1'b0;
      repeat (BIT_CLK) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BIT_CLK) @(negedge clk);
      end
      if (good) begin
         rx = 1'b1;
         repeat (BIT_CLK) @(negedge clk);
         exp_q.push_back(b);
         exp_dout = b;
      end else begin
         rx = 1'b0;
         repeat (BIT_CLK * 3 / 4) @(negedge clk);
         rx = 1'b1;
         repeat (BIT_CLK / 4) @(negedge clk);
         exp_err++;
      end
   endtask

   task automatic test_reset();
      rx    = 1'b1;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      tests_run++;
      if (d_out !== 8'h00) begin fails++; $display("FAIL reset_d_out: got %0h expected 00", d_out); end
      tests_run++;
      if (rx_done !== 1'b0) begin fails++; $display("FAIL reset_rx_done: got %0b expected 0", rx_done); end
      tests_run++;
      if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %0b expected 0", frame_err); end
      clear_obs();
      repeat (500) @(negedge clk);
      tests_run++;
      if (got_q.size() != 0) begin fails++; $display("FAIL reset_quiet_done: got %0d strobes expected 0", got_q.size()); end
      tests_run++;
      if (got_err != 0) begin fails++; $display("FAIL reset_quiet_err: got %0d strobes expected 0", got_err); end
   endtask

   task automatic test_single_byte();
      int lat;
      bit seen;
      clear_obs();
      lat  = 0;
      seen = 0;
      fork
         send_frame(8'h35, 1'b1);
         begin
            while (!seen && lat < 400) begin
               @(posedge clk);
               lat++;
               @(negedge clk);
               if (rx_done) seen = 1;
            end
         end
      join
      idle_bits(1);
      tests_run++;
      if (!seen) begin fails++; $display("FAIL single_timeout: no rx_done within %0d clk", lat); end
      tests_run++;
      if (lat < 306 || lat > 309) begin fails++; $display("FAIL single_latency: got %0d clk expected 306..309", lat); end
      tests_run++;
      if (got_q.size() != 1) begin fails++; $display("FAIL single_count: got %0d strobes expected 1", got_q.size()); end
      else begin
         tests_run++;
         if (got_q[0] !== 8'h35) begin fails++; $display("FAIL single_data: got %0h expected 35", got_q[0]); end
      end
      tests_run++;
      if (got_err != 0) begin fails++; $display("FAIL single_err: got %0d expected 0", got_err); end
      tests_run++;
      if (d_out !== exp_dout) begin fails++; $display("FAIL single_hold: got %0h expected %0h", d_out, exp_dout); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] cmd[6];
      cmd = '{8'h35, 8'h34, 8'h20, 8'h2B, 8'h37, 8'h20};
      clear_obs();
      for (int i = 0; i < 6; i++) send_frame(cmd[i], 1'b1);
      idle_bits(1);
      tests_run++;
      if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL b2b_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
      else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL b2b_data[%0d]: got %0h expected %0h", i, got_q[i], exp_q[i]); end
         end
      end
      tests_run++;
      if (got_err != 0) begin fails++; $display("FAIL b2b_err: got %0d expected 0", got_err); end
      tests_run++;
      if (d_out !== exp_dout) begin fails++; $display("FAIL b2b_hold: got %0h expected %0h", d_out, exp_dout); end
   endtask

   task automatic test_glitch();
      clear_obs();
      rx = 1'b0;
      repeat (8) @(negedge clk);
      rx = 1'b1;
      repeat (4 * BIT_CLK) @(negedge clk);
      tests_run++;
      if (got_q.size() != 0) begin fails++; $display("FAIL glitch_done: got %0d strobes expected 0", got_q.size()); end
      tests_run++;
      if (got_err != 0) begin fails++; $display("FAIL glitch_err: got %0d strobes expected 0", got_err); end
      send_frame(8'hA5, 1'b1);
      idle_bits(1);
      tests_run++;
      if (got_q.size() != 1) begin fails++; $display("FAIL glitch_after_count: got %0d expected 1", got_q.size()); end
      else begin
         tests_run++;
         if (got_q[0] !== 8'hA5) begin fails++; $display("FAIL glitch_after_data: got %0h expected a5", got_q[0]); end
      end
      tests_run++;
      if (d_out !== exp_dout) begin fails++; $display("FAIL glitch_after_hold: got %0h expected %0h", d_out, exp_dout); end
   endtask

   task automatic test_frame_err();
      clear_obs();
      send_frame(8'hFF, 1'b0);
      idle_bits(1);
      tests_run++;
      if (got_err != exp_err) begin fails++; $display("FAIL ferr_count: got %0d expected %0d", got_err, exp_err); end
      tests_run++;
      if (got_q.size() != 0) begin fails++; $display("FAIL ferr_done: got %0d strobes expected 0", got_q.size()); end
      tests_run++;
      if (d_out !== 8'hA5) begin fails++; $display("FAIL ferr_hold: got %0h expected a5", d_out); end
      send_frame(8'h3C, 1'b1);
      idle_bits(1);
      tests_run++;
      if (got_q.size() != 1) begin fails++; $display("FAIL ferr_after_count: got %0d expected 1", got_q.size()); end
      tests_run++;
      if (d_out !== 8'h3C) begin fails++; $display("FAIL ferr_after_data: got %0h expected 3c", d_out); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] b;
      b = 8'h55;
      clear_obs();
      rx = 1'b0;
      repeat (BIT_CLK) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = b[i];
         repeat (BIT_CLK) @(negedge clk);
      end
      rx = b[4];
      repeat (BIT_CLK / 2) @(negedge clk);
      reset = 1'b1;
      rx    = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      exp_dout = 8'h00;
      idle_bits(4);
      tests_run++;
      if (got_q.size() != 0 || got_err != 0) begin fails++; $display("FAIL rstmid_strobe: got %0d done %0d err expected 0 0", got_q.size(), got_err); end
      tests_run++;
      if (d_out !== 8'h00) begin fails++; $display("FAIL rstmid_d_out: got %0h expected 00", d_out); end
      send_frame(b, 1'b1);
      idle_bits(1);
      tests_run++;
      if (got_q.size() != 1) begin fails++; $display("FAIL rstmid_after_count: got %0d expected 1", got_q.size()); end
      tests_run++;
      if (d_out !== exp_dout) begin fails++; $display("FAIL rstmid_after_data: got %0h expected %0h", d_out, exp_dout); end
   endtask

   task automatic test_random();
      logic [7:0] b;
      bit         good;
      int         gap;
      clear_obs();
      for (int n = 0; n < 20; n++) begin
         b    = 8'($urandom);
         good = ($urandom_range(0, 3) != 0);
         send_frame(b, good);
         gap  = good ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
         if (gap > 0) idle_bits(gap);
      end
      idle_bits(1);
      tests_run++;
      if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
      else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL rand_data[%0d]: got %0h expected %0h", i, got_q[i], exp_q[i]); end
         end
      end
      tests_run++;
      if (got_err != exp_err) begin fails++; $display("FAIL rand_err: got %0d expected %0d", got_err, exp_err); end
      tests_run++;
      if (d_out !== exp_dout) begin fails++; $display("FAIL rand_hold: got %0h expected %0h", d_out, exp_dout); end
   endtask

   task automatic test_strobe_shape();
      tests_run++;
      if (overlap_cnt != 0) begin fails++; $display("FAIL strobe_overlap: got %0d cycles expected 0", overlap_cnt); end
      tests_run++;
      if (wide_cnt != 0) begin fails++; $display("FAIL strobe_width: got %0d wide pulses expected 0", wide_cnt); end
   endtask

   initial begin
      reset = 1'b1;
      rx    = 1'b1;
      @(negedge clk);
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_glitch();
      test_frame_err();
      test_reset_mid();
      test_random();
      test_strobe_shape();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver stage that sits directly upstream of the command `Interface` block. It converts the asynchronous 8N1 line `rx` into parallel bytes, using 16x oversampling with an internal baud-tick divider. Each good byte is presented on `d_out` with a one-cycle `rx_done` strobe, which connect directly to `Interface.d_in` and `Interface.rx_done`. Framing errors are flagged separately and never produce `rx_done`.

## Interface
- `DBIT`, 8: data bits per frame, sent LSB first.
- `SB_TICK`, 16: oversample ticks from the last data-bit sample to the stop-bit sample.
- `DIVISOR`, 163: `clk` cycles per oversample tick (50 MHz / (19200 × 16)); must be ≥ 2.
- `clk`  in  1  single system clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial line; idles high.
- `d_out`  out  DBIT  last correctly framed byte; holds until the next good frame.
- `rx_done`  out  1  one-`clk` pulse when `d_out` has just been updated.
- `frame_err`  out  1  one-`clk` pulse when the stop-bit sample is 0.

## Operation
- **Synchronizer:** `rx` passes through two flops, both reset to 1. All logic uses the synchronized copy, `rx_s`.
- **Tick generator:** free-running counter `0..DIVISOR-1`. `tick` is high for one cycle when the count equals `DIVISOR-1`, then the count wraps to 0. The counter runs in every state and is cleared only by reset.
- **Internal counters:** `s_cnt` (4 bits), `n_cnt` (`clog2(DBIT)` bits), shift register `sh` (`DBIT` bits).
- **IDLE:** checked every clock. If `rx_s==0`, go to START and set `s_cnt=0`.
- **START:** on each tick:
  - if `s_cnt==7` and `rx_s==0`: go to DATA, `s_cnt=0`, `n_cnt=0`;
  - if `s_cnt==7` and `rx_s==1`: glitch, return to IDLE with no outputs;
  - otherwise `s_cnt++`.
- **DATA:** on each tick:
  - if `s_cnt==15`: `sh <= {rx_s, sh[DBIT-1:1]}` and `s_cnt=0`; if `n_cnt==DBIT-1` go to STOP, else `n_cnt++`;
  - otherwise `s_cnt++`.
- **STOP:** on each tick:
  - if `s_cnt==SB_TICK-1` and `rx_s==1`: `d_out<=sh`, pulse `rx_done`, go to IDLE;
  - if `s_cnt==SB_TICK-1` and `rx_s==0`: pulse `frame_err`, leave `d_out` unchanged, go to IDLE;
  - otherwise `s_cnt++`.
- **Outputs:** `rx_done` and `frame_err` are registered. They are never high together, and each is high for at most one cycle per frame.
- **Break condition (line held low):** produces a frame of all zeros with `frame_err`. IDLE then immediately re-arms on the still-low line. This is the required behaviour.

## Timing
- **Reset values:** `d_out=0`, `rx_done=0`, `frame_err=0`, state IDLE, all counters 0, sync flops 1.
- **Reset mid-frame:** aborts the frame, forces the reset values, and produces no strobe. A frame already in progress when reset is released is not recovered.
- **Sample points:** start bit is checked at tick 8 after detection. Each data bit is sampled 16 ticks later, near bit centre. The stop bit is sampled `SB_TICK` ticks after the last data bit.
- **Latency:** from the first low `rx` edge to `rx_done` high is 152 ticks plus synchronizer and phase delay. In clocks this is between `152*DIVISOR+2` and `153*DIVISOR+3`.
- **Strobe timing:** `rx_done` is high for exactly one `clk`. `d_out` is valid in the same cycle as `rx_done` and stays stable afterwards.
- **Back-to-back frames:** a new start bit arriving right after a stop bit is accepted. Because IDLE is re-entered at mid-stop, this gives a minimum inter-frame gap of 0 idle bits.
- **Tolerance:** at `DIVISOR` ≥ 2, baud mismatch up to ±2 % is tolerated.

## Test plan
- **Reset values:** use `DIVISOR=2` (1 bit = 32 `clk`). Assert reset for 3 cycles with `rx=1` → `d_out=0x00`, `rx_done=0`, `frame_err=0`; no strobe for 500 cycles.
- **Single byte:** send 0x35 ('5') → exactly one `rx_done` pulse, `d_out=0x35`, latency within [306, 309] clk of the start edge, `frame_err=0`.
- **Back-to-back command:** send 0x35, 0x34, 0x20, 0x2B, 0x37, 0x20 with no idle gap → six `rx_done` pulses with `d_out` taking exactly that sequence; no `frame_err`.
- **Start-bit glitch:** drive `rx` low for 8 clk (less than half a bit), then high → no `rx_done` and no `frame_err`. A subsequent 0xA5 is received correctly.
- **Framing error:** send 0xFF with the stop bit forced low → `frame_err` pulses once, `rx_done` stays 0, `d_out` keeps its prior value 0xA5. A following 0x3C received after a 1-bit idle gives `d_out=0x3C`.
- **Reset mid-frame:** assert reset during data bit 4 of 0x55 → no strobe and `d_out=0x00`. Send 0x55 again after reset → `d_out=0x55`, one `rx_done`.
